cmd_sequencer: RTL and testbench

Turns word-level configuration writes into the serial 8-bit command stream consumed by the command parser. It sits between the host-side register front end and the parser's `cmd` input. It accepts one request at a time over a valid/ready handshake and emits one command byte per cycle. A no-op byte is driven whenever it is idle.

---
 rtl/cmd_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_cmd_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: serialises one latched configuration request into parser command bytes,
// with a one-entry line cache that skips the LINE preamble for repeated writes to the same line.
module cmd_sequencer #(
  parameter int NUM_INPUTS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_line,
  input  logic [1:0]  req_field,
  input  logic        req_auto,
  input  logic [15:0] req_value,
  input  logic [2:0]  cap_flags,
  output logic [7:0]  cmd,
  output logic        done,
  output logic        err
);

  localparam logic [7:0] NOP     = 8'h0F;
  localparam logic [1:0] F_VOLT  = 2'd0;
  localparam logic [1:0] F_TEST  = 2'd1;
  localparam logic [1:0] F_LEN   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT, S_ERR} state_t;
  typedef enum logic [1:0] {P_LINE, P_CAP, P_DATA} phase_t;

  function automatic logic [2:0] data_last(input logic [1:0] field);
    case (field)
      F_VOLT:  data_last = 3'd3;
      F_TEST:  data_last = 3'd0;
      default: data_last = 3'd5;
    endcase
  endfunction

  // Byte for a sequence position; DATA idx 4..5 of START/LEN are the two trailing j-bytes.
  function automatic logic [7:0] byte_of(input phase_t ph, input logic [2:0] idx, input logic pass,
                                         input logic [7:0] line, input logic [1:0] field,
                                         input logic a, input logic [15:0] v, input logic [2:0] flags);
    logic       x;
    logic [3:0] off;
    x   = (field == F_TEST) ? pass : (field == F_LEN);
    off = {1'b0, idx[1:0], 1'b0} + {2'b00, idx[1:0]};
    case (ph)
      P_LINE: byte_of = {idx[1:0], line[{idx[1:0], 1'b0} +: 2], 4'h1};
      P_CAP:  byte_of = {x, flags, 4'hD};
      P_DATA: begin
        case (field)
          F_VOLT:  byte_of = {idx[1:0], v[{1'b0, idx[1:0], 1'b0} +: 2], 4'h9};
          F_TEST:  byte_of = {(pass ? v[7:4] : v[3:0]), 4'hC};
          default: begin
            if (idx[2]) byte_of = {a, idx[0], v[{2'b11, idx[0], 1'b0} +: 2], 4'h8};
            else        byte_of = {a, v[off +: 3], 2'b01, idx[1:0]};
          end
        endcase
      end
      default: byte_of = NOP;
    endcase
  endfunction

  state_t      state_q;
  phase_t      phase_q, phase_d;
  logic [2:0]  idx_q, idx_d;
  logic        pass_q, pass_d;
  logic [7:0]  line_q, last_line_q;
  logic [1:0]  field_q;
  logic        auto_q, line_valid_q;
  logic [15:0] value_q;
  logic [2:0]  flags_q;
  logic [7:0]  cmd_q, nbyte_d;
  logic        ready_q, done_q, err_q, nlast_d;
  logic        skip_s, range_err_s;

  // Next sequence position and the byte/last flag that go with it.
  always_comb begin
    skip_s      = line_valid_q && (last_line_q == line_q);
    range_err_s = ({24'd0, line_q} >= 32'(NUM_INPUTS));
    phase_d     = P_LINE;
    idx_d       = 3'd0;
    pass_d      = 1'b0;
    if (state_q == S_LOAD) begin
      if (skip_s) phase_d = (field_q == F_VOLT) ? P_DATA : P_CAP;
      else        phase_d = P_LINE;
    end else begin
      case (phase_q)
        P_LINE: begin
          if (idx_q == 3'd3) phase_d = (field_q == F_VOLT) ? P_DATA : P_CAP;
          else begin
            phase_d = P_LINE;
            idx_d   = idx_q + 3'd1;
          end
        end
        P_CAP: begin
          phase_d = P_DATA;
          pass_d  = pass_q;
        end
        P_DATA: begin
          // Only TEST's first pass reaches its data end without being last.
          if (idx_q == data_last(field_q)) begin
            phase_d = P_CAP;
            pass_d  = 1'b1;
          end else begin
            phase_d = P_DATA;
            idx_d   = idx_q + 3'd1;
            pass_d  = pass_q;
          end
        end
        default: phase_d = P_LINE;
      endcase
    end
    nbyte_d = byte_of(phase_d, idx_d, pass_d, line_q, field_q, auto_q, value_q, flags_q);
    nlast_d = (phase_d == P_DATA) && (idx_d == data_last(field_q)) &&
              ((field_q != F_TEST) || pass_d);
  end

  // Sequencer FSM with registered byte, handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      phase_q      <= P_LINE;
      idx_q        <= 3'd0;
      pass_q       <= 1'b0;
      line_q       <= 8'd0;
      field_q      <= 2'd0;
      auto_q       <= 1'b0;
      value_q      <= 16'd0;
      flags_q      <= 3'd0;
      last_line_q  <= 8'd0;
      line_valid_q <= 1'b0;
      cmd_q        <= NOP;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_q <= NOP;
          if (req_valid) begin
            line_q  <= req_line;
            field_q <= req_field;
            auto_q  <= req_auto;
            value_q <= req_value;
            flags_q <= cap_flags;
            ready_q <= 1'b0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (range_err_s) begin
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end else begin
            phase_q <= phase_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            cmd_q   <= nbyte_d;
            done_q  <= nlast_d;
            if (!skip_s) begin
              last_line_q  <= line_q;
              line_valid_q <= 1'b1;
            end
            state_q <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (done_q) begin
            cmd_q   <= NOP;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            phase_q <= phase_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            cmd_q   <= nbyte_d;
            done_q  <= nlast_d;
          end
        end
        S_ERR: begin
          err_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          cmd_q   <= NOP;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign cmd       = cmd_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer: directed plan steps then random requests, checked against a
// byte-list model built from the command formulas plus a modelled one-entry line cache.
module tb_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        sel_small = 1'b0;
  logic [7:0]  req_line = 8'd0;
  logic [1:0]  req_field = 2'd0;
  logic        req_auto = 1'b0;
  logic [15:0] req_value = 16'd0;
  logic [2:0]  cap_flags = 3'd0;

  logic        b_ready, b_done, b_err, s_ready, s_done, s_err;
  logic [7:0]  b_cmd, s_cmd;
  logic        o_ready, o_done, o_err;
  logic [7:0]  o_cmd;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  bit         mvalid[2];
  logic [7:0] mline[2];
  int         num_in[2];

  always #5 clk = ~clk;

  cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && !sel_small), .req_ready(b_ready),
    .req_line(req_line), .req_field(req_field), .req_auto(req_auto), .req_value(req_value),
    .cap_flags(cap_flags), .cmd(b_cmd), .done(b_done), .err(b_err)
  );

  cmd_sequencer #(.NUM_INPUTS(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel_small), .req_ready(s_ready),
    .req_line(req_line), .req_field(req_field), .req_auto(req_auto), .req_value(req_value),
    .cap_flags(cap_flags), .cmd(s_cmd), .done(s_done), .err(s_err)
  );

  assign o_ready = sel_small ? s_ready : b_ready;
  assign o_done  = sel_small ? s_done  : b_done;
  assign o_err   = sel_small ? s_err   : b_err;
  assign o_cmd   = sel_small ? s_cmd   : b_cmd;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic void push_cap(input int x, input logic [2:0] f);
    exp_q.push_back(8'(x * 128 + int'(f) * 16 + 13));
  endfunction

  // Expected byte list of one accepted request.
  function automatic void build(input logic [7:0] line, input logic [1:0] field, input logic a,
                                input logic [15:0] v, input logic [2:0] f, input bit skip);
    int li, vi, ai;
    li = int'(line);
    vi = int'(v);
    ai = a ? 1 : 0;
    exp_q.delete();
    if (!skip)
      for (int i = 0; i < 4; i++) exp_q.push_back(8'(i * 64 + ((li >> (2 * i)) % 4) * 16 + 1));
    case (field)
      2'd0: for (int i = 0; i < 4; i++) exp_q.push_back(8'(i * 64 + ((vi >> (2 * i)) % 4) * 16 + 9));
      2'd1: begin
        push_cap(0, f);
        exp_q.push_back(8'((vi % 16) * 16 + 12));
        push_cap(1, f);
        exp_q.push_back(8'(((vi / 16) % 16) * 16 + 12));
      end
      default: begin
        push_cap((field == 2'd3) ? 1 : 0, f);
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(ai * 128 + ((vi >> (3 * k)) % 8) * 16 + 4 + k));
        for (int j = 0; j < 2; j++) exp_q.push_back(8'(ai * 128 + j * 64 + ((vi >> (12 + 2 * j)) % 4) * 16 + 8));
      end
    endcase
  endfunction

  task automatic do_req(input bit sel, input logic [7:0] line, input logic [1:0] field, input logic a,
                        input logic [15:0] v, input logic [2:0] f, input int abort_after);
    int waitc, s, n_exp;
    bit rej, skip;
    s = sel ? 1 : 0;
    sel_small = sel;
    #1;
    waitc = 0;
    while (o_ready !== 1'b1 && waitc < 40) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    check("accept_ready", 16'(o_ready), 16'd1);
    req_line  = line;
    req_field = field;
    req_auto  = a;
    req_value = v;
    cap_flags = f;
    req_valid = 1'b1;
    rej  = (int'(line) >= num_in[s]);
    skip = mvalid[s] && (mline[s] == line);
    if (!rej) begin
      build(line, field, a, v, f, skip);
      mvalid[s] = 1'b1;
      mline[s]  = line;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_line  = 8'($urandom);
    req_field = 2'($urandom);
    req_auto  = 1'($urandom);
    req_value = 16'($urandom);
    cap_flags = 3'($urandom);
    @(negedge clk);
    check("load_cmd", 16'(o_cmd), 16'h0F);
    check("load_ready", 16'(o_ready), 16'd0);
    check("load_done", 16'(o_done), 16'd0);
    check("load_err", 16'(o_err), 16'd0);
    if (rej) begin
      @(negedge clk);
      check("rej_err", 16'(o_err), 16'd1);
      check("rej_cmd", 16'(o_cmd), 16'h0F);
      check("rej_ready", 16'(o_ready), 16'd0);
      @(negedge clk);
      check("rej_err_clr", 16'(o_err), 16'd0);
      check("rej_ready_back", 16'(o_ready), 16'd1);
      check("rej_cmd_nop", 16'(o_cmd), 16'h0F);
      return;
    end
    n_exp = exp_q.size();
    for (int n = 0; n < n_exp; n++) begin
      @(negedge clk);
      check("byte", 16'(o_cmd), 16'(exp_q[n]));
      check("byte_done", 16'(o_done), (n == n_exp - 1) ? 16'd1 : 16'd0);
      check("busy_ready", 16'(o_ready), 16'd0);
      check("busy_err", 16'(o_err), 16'd0);
      if (abort_after == n + 1) begin
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_cmd", 16'(o_cmd), 16'h0F);
        check("abort_ready", 16'(o_ready), 16'd1);
        check("abort_done", 16'(o_done), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mvalid[0] = 1'b0;
        mvalid[1] = 1'b0;
        @(negedge clk);
        check("post_abort_ready", 16'(o_ready), 16'd1);
        check("post_abort_cmd", 16'(o_cmd), 16'h0F);
        return;
      end
      // Requests raised while busy must be ignored.
      req_valid = (n < n_exp - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    @(negedge clk);
    check("idle_cmd", 16'(o_cmd), 16'h0F);
    check("idle_ready", 16'(o_ready), 16'd1);
    check("idle_done", 16'(o_done), 16'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired before the end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rl;
    bit rs;
    int r, ab;
    num_in[0] = 256;
    num_in[1] = 4;
    mvalid[0] = 1'b0;
    mvalid[1] = 1'b0;
    mline[0]  = 8'd0;
    mline[1]  = 8'd0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd", 16'(b_cmd), 16'h0F);
    check("rst_ready", 16'(b_ready), 16'd1);
    check("rst_done", 16'(b_done), 16'd0);
    check("rst_err", 16'(b_err), 16'd0);
    check("rst_small_ready", 16'(s_ready), 16'd1);

    do_req(1'b0, 8'd5, 2'd2, 1'b1, 16'hABCD, 3'b000, 0);
    do_req(1'b0, 8'd5, 2'd3, 1'b0, 16'h0003, 3'b000, 0);
    do_req(1'b0, 8'h80, 2'd0, 1'b0, 16'h00E4, 3'b000, 0);
    do_req(1'b0, 8'h80, 2'd1, 1'b0, 16'h00A5, 3'b001, 0);

    do_req(1'b1, 8'd4, 2'd0, 1'b0, 16'h1234, 3'b010, 0);
    do_req(1'b1, 8'd2, 2'd0, 1'b0, 16'h00C6, 3'b010, 0);
    do_req(1'b1, 8'd3, 2'd3, 1'b1, 16'h5A5A, 3'b111, 0);

    do_req(1'b0, 8'h33, 2'd2, 1'b1, 16'h7E81, 3'b101, 3);
    do_req(1'b0, 8'h33, 2'd2, 1'b1, 16'h7E81, 3'b101, 0);

    for (int t = 0; t < 60; t++) begin
      rs = ($urandom_range(0, 3) == 0);
      r  = $urandom_range(0, 3);
      if (r == 0)      rl = mline[rs ? 1 : 0];
      else if (r == 1) rl = 8'($urandom_range(0, 7));
      else             rl = 8'($urandom);
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 0;
      do_req(rs, rl, 2'($urandom), 1'($urandom), 16'($urandom), 3'($urandom), ab);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
